// File: rtl/pio_in_debounce_irq.sv
// Multi-channel input PIO: per-bit synchroniser, counter debounce, rise/fall edge
// capture (write-1-to-clear), interrupt mask and a level irq, on an Avalon-MM slave.
module pio_in_debounce_irq #(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic [2:0] ADDR_DATA  = 3'd0;
   localparam logic [2:0] ADDR_RISE  = 3'd1;
   localparam logic [2:0] ADDR_MASK  = 3'd2;
   localparam logic [2:0] ADDR_EDGE  = 3'd3;
   localparam logic [2:0] ADDR_FALL  = 3'd4;

   // In bypass mode the q register acts as the final synchroniser stage, so the
   // in_port-to-q latency stays at SYNC_STAGES edges.
   localparam int CHAIN = (DEBOUNCE_CYCLES == 0) ? SYNC_STAGES - 1 : SYNC_STAGES;

   logic [WIDTH-1:0] sync_r [CHAIN];
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] ec_clr;
   logic             wr;
   logic [31:0]      rd_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHAIN; i++) sync_r[i] <= '0;
      end else begin
         sync_r[0] <= in_port;
         for (int i = 1; i < CHAIN; i++) sync_r[i] <= sync_r[i-1];
      end
   end

   assign s = sync_r[CHAIN-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) q <= '0;
            else          q <= s;
         end
      end else begin : g_debounce
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
         logic [CNT_W-1:0] cnt [WIDTH];

         // The count only advances while s disagrees with q, so any bounce back
         // to the accepted level restarts the qualification window.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               q <= '0;
               for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
            end else begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (s[i] == q[i]) begin
                     cnt[i] <= '0;
                  end else if (cnt[i] == CNT_LAST) begin
                     q[i]   <= s[i];
                     cnt[i] <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + 1'b1;
                  end
               end
            end
         end
      end

      if (WIDTH < 32) begin : g_wd_upper
         logic unused_wd_upper;
         assign unused_wd_upper = ^writedata[31:WIDTH];
      end
   endgenerate

   assign wd     = writedata[WIDTH-1:0];
   assign wr     = chipselect & ~write_n;
   assign rise   = q & ~q_d & rise_en;
   assign fall   = ~q & q_d & fall_en;
   assign ec_clr = (wr && address == ADDR_EDGE) ? wd : '0;

   // New events are OR-ed in after the clear so a same-cycle clear cannot lose them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_d          <= '0;
         edge_capture <= '0;
         rise_en      <= '0;
         fall_en      <= '0;
         irqmask      <= '0;
      end else begin
         q_d          <= q;
         edge_capture <= (edge_capture & ~ec_clr) | rise | fall;
         if (wr && address == ADDR_RISE) rise_en <= wd;
         if (wr && address == ADDR_MASK) irqmask <= wd;
         if (wr && address == ADDR_FALL) fall_en <= wd;
      end
   end

   always_comb begin
      rd_next = '0;
      case (address)
         ADDR_DATA: rd_next[WIDTH-1:0] = q;
         ADDR_RISE: rd_next[WIDTH-1:0] = rise_en;
         ADDR_MASK: rd_next[WIDTH-1:0] = irqmask;
         ADDR_EDGE: rd_next[WIDTH-1:0] = edge_capture;
         ADDR_FALL: rd_next[WIDTH-1:0] = fall_en;
         default:   rd_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_next;
   end

   assign irq = |(edge_capture & irqmask);

endmodule
